// File: rtl/adc_spi_sampler.sv
// Serial ADC front end: clocks 16-bit frames out of an AD7476A-style converter,
// averages 2^AVG_LOG2 accepted samples and publishes the top nibble as a duty code.
//
// state | meaning
// IDLE  | CS_N high, counting the inter-frame gap
// FRAME | CS_N low, generating SCLK and shifting in SDATA
// DONE  | one cycle: validate frame, accumulate, maybe publish
module adc_spi_sampler #(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_GAP = 100,
  parameter int AVG_LOG2   = 2
) (
  input  logic        cLK,
  input  logic        Reset,
  input  logic        SDATA,
  output logic        CS_N,
  output logic        SCLK,
  output logic [3:0]  ADC,
  output logic        VALID,
  output logic [11:0] SAMPLE_RAW,
  output logic        ERR
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [4:0]       CNT_LAST = 5'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      shift;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [4:0]       avg_cnt;

  // Accumulator is sized so 2^AVG_LOG2 full-scale samples cannot overflow.
  assign acc_sum = acc + ACC_W'(shift[11:0]);

  always_ff @(posedge cLK) begin
    if (Reset) begin
      state      <= S_IDLE;
      CS_N       <= 1'b1;
      SCLK       <= 1'b1;
      ADC        <= '0;
      VALID      <= 1'b0;
      SAMPLE_RAW <= '0;
      ERR        <= 1'b0;
      gap_cnt    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      acc        <= '0;
      avg_cnt    <= '0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        S_IDLE: begin
          CS_N <= 1'b1;
          SCLK <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            CS_N    <= 1'b0;
            state   <= S_FRAME;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_FRAME: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= ~SCLK;
            // SCLK currently low, so this toggle is a rising edge: sample now
            if (!SCLK) begin
              shift   <= {shift[14:0], SDATA};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                CS_N  <= 1'b1;
                state <= S_DONE;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (shift[15:12] != 4'd0) begin
            ERR <= 1'b1;
          end else begin
            SAMPLE_RAW <= shift[11:0];
            if (avg_cnt == CNT_LAST) begin
              ADC     <= acc_sum[ACC_W-1 -: 4];
              VALID   <= 1'b1;
              acc     <= '0;
              avg_cnt <= '0;
            end else begin
              acc     <= acc_sum;
              avg_cnt <= avg_cnt + 5'd1;
            end
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench for adc_spi_sampler: an ADC model serves queued frame words,
// expected per-frame outcomes are queued at CS_N fall and checked when DONE resolves.
module tb_adc_spi_sampler;

  localparam int CLK_DIV    = 2;
  localparam int SAMPLE_GAP = 4;
  localparam int LOW_CYC    = 32 * CLK_DIV;
  localparam int PERIOD     = SAMPLE_GAP + LOW_CYC + 1;
  localparam int NAVG       = 4;

  typedef struct packed {
    logic        err;
    logic        pub;
    logic [11:0] raw;
    logic [3:0]  adc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // averaging instance (AVG_LOG2=2)
  logic        rst_a, sdata_a, cs_n_a, sclk_a, valid_a, err_a;
  logic [3:0]  adc_a;
  logic [11:0] raw_a;
  // single-sample instance (AVG_LOG2=0)
  logic        rst_s, sdata_s, cs_n_s, sclk_s, valid_s, err_s;
  logic [3:0]  adc_s;
  logic [11:0] raw_s;

  adc_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_GAP(SAMPLE_GAP), .AVG_LOG2(2)) dut_avg (
    .cLK(clk), .Reset(rst_a), .SDATA(sdata_a), .CS_N(cs_n_a), .SCLK(sclk_a),
    .ADC(adc_a), .VALID(valid_a), .SAMPLE_RAW(raw_a), .ERR(err_a));

  adc_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_GAP(SAMPLE_GAP), .AVG_LOG2(0)) dut_single (
    .cLK(clk), .Reset(rst_s), .SDATA(sdata_s), .CS_N(cs_n_s), .SCLK(sclk_s),
    .ADC(adc_s), .VALID(valid_s), .SAMPLE_RAW(raw_s), .ERR(err_s));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- averaging instance: ADC model + reference ----------------
  logic [15:0] word_q_a[$];
  exp_t        exp_q_a[$];
  logic [15:0] cur_a = 16'hF000;
  int          nfall_a = 0;
  int          m_acc = 0, m_cnt = 0;
  logic [11:0] m_raw = '0;
  exp_t        e_mod;

  always @(negedge cs_n_a) begin
    cur_a   = (word_q_a.size() != 0) ? word_q_a.pop_front() : 16'hF000;
    nfall_a = 0;
    e_mod   = '0;
    if (cur_a[15:12] != 4'd0) begin
      e_mod.err = 1'b1;
      e_mod.raw = m_raw;
    end else begin
      m_raw     = cur_a[11:0];
      e_mod.raw = m_raw;
      m_acc    += int'(cur_a[11:0]);
      m_cnt++;
      if (m_cnt == NAVG) begin
        e_mod.pub = 1'b1;
        e_mod.adc = 4'((m_acc / NAVG) / 256);
        m_acc = 0;
        m_cnt = 0;
      end
    end
    exp_q_a.push_back(e_mod);
  end

  // converter shifts the next bit out on each falling SCLK, MSB first
  always @(negedge sclk_a) begin
    if (cs_n_a === 1'b0 && nfall_a < 16) begin
      sdata_a = cur_a[15 - nfall_a];
      nfall_a++;
    end
  end

  task automatic flush_a();
    word_q_a.delete();
    exp_q_a.delete();
    m_acc = 0;
    m_cnt = 0;
    m_raw = '0;
  endtask

  // ---------------- averaging instance: monitor ----------------
  logic       cs_prev = 1'b1, sclk_prev = 1'b1, pend = 1'b0;
  logic [3:0] last_adc_a = '0;
  int         low_cnt = 0, rise_cnt_a = 0, valid_cnt_a = 0, err_cnt_a = 0;
  exp_t       e_mon;

  always @(negedge clk) begin
    if (rst_a) begin
      cs_prev = 1'b1; sclk_prev = 1'b1; pend = 1'b0;
      last_adc_a = '0; low_cnt = 0; rise_cnt_a = 0;
    end else begin
      if (valid_a) valid_cnt_a++;
      if (err_a) err_cnt_a++;
      if (cs_prev && !cs_n_a) begin
        low_cnt = 0;
        rise_cnt_a = 0;
      end
      if (!cs_n_a) low_cnt++;
      if (!sclk_prev && sclk_a) rise_cnt_a++;

      if (pend) begin
        pend = 1'b0;
        if (exp_q_a.size() == 0) chk("exp_underflow", 1, 0);
        else begin
          e_mon = exp_q_a.pop_front();
          chk("err_pulse", int'(err_a), int'(e_mon.err));
          chk("valid_pulse", int'(valid_a), int'(e_mon.pub));
          chk("sample_raw", int'(raw_a), int'(e_mon.raw));
          if (e_mon.pub) last_adc_a = e_mon.adc;
          chk("adc_value", int'(adc_a), int'(last_adc_a));
        end
      end else begin
        chk("hold", int'({valid_a, err_a, adc_a}), int'({2'b00, last_adc_a}));
      end

      if (!cs_prev && cs_n_a) begin
        chk("cs_low_cycles", low_cnt, LOW_CYC);
        chk("sclk_rises", rise_cnt_a, 16);
        pend = 1'b1;
      end
      cs_prev   = cs_n_a;
      sclk_prev = sclk_a;
    end
  end

  // ---------------- single-sample instance: model + monitor ----------------
  logic [15:0] word_q_s[$];
  logic [3:0]  exp_s[$];
  logic [15:0] cur_s = 16'hF000;
  int          nfall_s = 0, valid_cnt_s = 0;

  always @(negedge cs_n_s) begin
    cur_s   = (word_q_s.size() != 0) ? word_q_s.pop_front() : 16'hF000;
    nfall_s = 0;
    if (cur_s[15:12] == 4'd0) exp_s.push_back(4'(int'(cur_s[11:0]) / 256));
  end

  always @(negedge sclk_s) begin
    if (cs_n_s === 1'b0 && nfall_s < 16) begin
      sdata_s = cur_s[15 - nfall_s];
      nfall_s++;
    end
  end

  always @(negedge clk) begin
    if (!rst_s && valid_s) begin
      valid_cnt_s++;
      if (exp_s.size() == 0) chk("valid_s_unexpected", 1, 0);
      else chk("adc_s", int'(adc_s), int'(exp_s.pop_front()));
    end
  end

  // ---------------- helpers ----------------
  task automatic drain_a(input int budget);
    int n = 0;
    while ((word_q_a.size() != 0 || exp_q_a.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_a", word_q_a.size() + exp_q_a.size(), 0);
  endtask

  task automatic wait_cs_fall_a(input int budget);
    logic prev;
    bit   found = 1'b0;
    prev = cs_n_a;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (prev && !cs_n_a) found = 1'b1;
      prev = cs_n_a;
    end
    chk("cs_fall_wait", int'(found), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1; rst_s = 1'b1; sdata_a = 1'b0; sdata_s = 1'b0;
    flush_a();
    repeat (3) @(posedge clk); #1;
    chk("rst_cs_n", int'(cs_n_a), 1);
    chk("rst_sclk", int'(sclk_a), 1);
    chk("rst_adc", int'(adc_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_raw", int'(raw_a), 0);

    // full-scale samples, gap timing after release
    for (int i = 0; i < 4; i++) word_q_a.push_back(16'h0FFF);
    valid_cnt_a = 0;
    rst_a = 1'b0;
    repeat (SAMPLE_GAP - 1) @(posedge clk); #1;
    chk("gap_cs_high", int'(cs_n_a), 1);
    @(posedge clk); #1;
    chk("gap_cs_fall", int'(cs_n_a), 0);
    drain_a(8 * PERIOD);
    chk("t1_valid_cnt", valid_cnt_a, 1);
    chk("t1_adc", int'(adc_a), 15);
    chk("t1_raw", int'(raw_a), 12'hFFF);
    repeat (2 * PERIOD) @(posedge clk); #1;
    chk("t1_adc_held", int'(adc_a), 15);
    chk("t1_no_extra_valid", valid_cnt_a, 1);

    // truncating average of distinct samples
    valid_cnt_a = 0;
    word_q_a.push_back(16'h0100);
    word_q_a.push_back(16'h0200);
    word_q_a.push_back(16'h0300);
    word_q_a.push_back(16'h0400);
    drain_a(8 * PERIOD);
    chk("t2_valid_cnt", valid_cnt_a, 1);
    chk("t2_adc", int'(adc_a), 2);
    chk("t2_raw", int'(raw_a), 12'h400);

    // rejected frame does not count toward the average
    valid_cnt_a = 0;
    err_cnt_a   = 0;
    word_q_a.push_back(16'h8FFF);
    for (int i = 0; i < 4; i++) word_q_a.push_back(16'h0800);
    drain_a(10 * PERIOD);
    chk("t3_err_cnt", err_cnt_a, 1);
    chk("t3_valid_cnt", valid_cnt_a, 1);
    chk("t3_adc", int'(adc_a), 8);
    chk("t3_raw", int'(raw_a), 12'h800);

    // abort on the 7th rising SCLK edge of the third frame
    word_q_a.push_back(16'h0FFF);
    word_q_a.push_back(16'h0FFF);
    word_q_a.push_back(16'h0ABC);
    for (int f = 0; f < 3; f++) wait_cs_fall_a(2 * PERIOD);
    repeat (14 * CLK_DIV - 1) @(posedge clk); #1;
    chk("abort_pre_rises", rise_cnt_a, 6);
    chk("abort_pre_sclk", int'(sclk_a), 0);
    rst_a = 1'b1;
    flush_a();
    @(posedge clk); #1;
    chk("abort_cs_n", int'(cs_n_a), 1);
    chk("abort_sclk", int'(sclk_a), 1);
    chk("abort_adc", int'(adc_a), 0);
    chk("abort_raw", int'(raw_a), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) word_q_a.push_back(16'h0300);
    valid_cnt_a = 0;
    rst_a = 1'b0;
    drain_a(8 * PERIOD);
    chk("t4_valid_cnt", valid_cnt_a, 1);
    chk("t4_adc", int'(adc_a), 3);

    // AVG_LOG2=0: each accepted frame publishes directly
    word_q_s.push_back(16'h07FF);
    word_q_s.push_back(16'h0000);
    rst_s = 1'b0;
    for (int n = 0; n < 6 * PERIOD && (word_q_s.size() != 0 || exp_s.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    chk("t5_drain", word_q_s.size() + exp_s.size(), 0);
    chk("t5_valid_cnt", valid_cnt_s, 2);
    chk("t5_adc", int'(adc_s), 0);
    chk("t5_raw", int'(raw_s), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
